mult_seq_core: RTL and testbench
================================

Name: mult_seq_core

Overview:
- Sequential signed 16x16 multiplier with parity-protected operands; it is the DUT-side responder to the multiplier test-pattern generator and BFM.
- Operands are accepted on a req/ack handshake and their parity is checked.
- The product is computed by a radix-2 shift-add datapath and returned with result parity and a one-cycle result_rdy pulse.
- Parity failures are reported through arg_parity_error instead of computing a product.

Parameters:
- DATA_W, 16, operand width in bits (signed); result width is 2*DATA_W.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W > DATA_W.

Ports:
- clk  input  1  clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  initiator request; operands valid while high.
- arg_a  input  DATA_W  operand A, signed.
- arg_a_parity  input  1  parity of arg_a; correct when equal to the XOR-reduction of arg_a.
- arg_b  input  DATA_W  operand B, signed.
- arg_b_parity  input  1  parity of arg_b; correct when equal to the XOR-reduction of arg_b.
- ack  output  1  one-cycle pulse: operands captured.
- result  output  2*DATA_W  signed product, registered.
- result_parity  output  1  XOR-reduction of result.
- result_rdy  output  1  one-cycle pulse: result, result_parity and arg_parity_error are valid.
- arg_parity_error  output  1  high when the last transaction had a bad parity on A, B or both.

Behaviour:
- Reset: clk and asynchronous active-low reset rst_n are fixed.
  - While rst_n=0: state=IDLE, ack=0, result=0, result_parity=0, result_rdy=0, arg_parity_error=0, counter=0.
  - Reset asserted mid-operation aborts the transaction. No result_rdy is produced for it.
- States: IDLE, CALC, ERR, DONE.
- IDLE:
  - At the edge E0 where req=1, capture arg_a, arg_b and both parity bits, and set ack=1 for the cycle following E0.
  - If both parities are correct, go to CALC.
  - Otherwise go to ERR.
  - req=0 stays in IDLE.
- CALC:
  - At capture, register sign = MSB(A) XOR MSB(B) and the magnitudes |A| and |B| as unsigned DATA_W+1 bits, so |-32768| = 32768 is representable.
  - Run DATA_W iterations, one per clock. Each iteration conditionally adds the multiplicand based on the multiplier LSB, then shifts.
  - After iteration DATA_W, go to DONE.
- DONE:
  - result <= sign ? -product : product, truncated to 2*DATA_W.
  - result_parity <= ^(that value); arg_parity_error <= 0; result_rdy=1 for this one cycle; then go to IDLE.
- ERR:
  - result <= 0, result_parity <= 0, arg_parity_error <= 1, result_rdy=1 for one cycle; then go to IDLE.
- Latency, measured from capture edge E0:
  - Valid operands: result_rdy is high in the cycle following edge E0+17.
  - Parity error: result_rdy is high in the cycle following edge E0+1.
- Output holding: result, result_parity and arg_parity_error hold their values until the next result_rdy; they are not cleared in IDLE.
- req in CALC, ERR or DONE is ignored; no ack is issued.
- req held high continuously gives back-to-back transactions. A new capture occurs on the first IDLE edge after DONE or ERR, one cycle after result_rdy.
- Operand inputs are sampled only at the capture edge. Later changes have no effect on the in-flight computation.
- Arithmetic:
  - The full 32-bit signed product is always exact; no overflow is possible.
  - A zero operand yields result 0 with result_parity 0, regardless of sign.
- ack and result_rdy are never high in the same cycle.

Test Plan:
- Reset, then req with A=0x7FFF, B=0x7FFF, both parities correct:
  - ack one cycle after the capture edge.
  - result_rdy after 17 more edges with result=0x3FFF0001, result_parity=1, arg_parity_error=0.
- A=0x8000, B=0x8000, parities correct -> result=0x40000000, result_parity=1, arg_parity_error=0.
- A=0x7FFF, B=0x8000, parities correct -> result=0xC0008000, result_parity=1.
- A=0x7FFF with arg_a_parity inverted (0), B=0x8000 correct:
  - result_rdy two edges after capture.
  - result=0, result_parity=0, arg_parity_error=1.
  - Next transaction with good parity clears arg_parity_error.
- req held high for 3 transactions with A/B alternating 0x7FFF/0x8000:
  - exactly 3 ack pulses, each one cycle after the preceding result_rdy.
  - operand changes during CALC ignored.
  - results match the golden model.
- rst_n pulsed low 5 cycles into CALC:
  - all outputs 0 immediately (asynchronously), no result_rdy for the aborted transaction.
  - after release, the next req is accepted normally.

Source files
------------

// File: rtl/mult_seq_if.sv
// Operand/result bundle for the sequential signed multiplier.
// The initiator drives the operand signals; the core drives ack, the result signals and dbg_state.
interface mult_seq_if #(
  parameter int DATA_W = 16
);
  // req/ack: the initiator holds req high with stable operands and parity.
  // The core samples them on one rising edge while idle and answers with a single-cycle ack.
  // result_rdy is a single-cycle pulse marking result, result_parity and arg_parity_error as valid.
  logic                  req;
  logic [DATA_W-1:0]     arg_a;
  logic                  arg_a_parity;
  logic [DATA_W-1:0]     arg_b;
  logic                  arg_b_parity;
  logic                  ack;
  logic [2*DATA_W-1:0]   result;
  logic                  result_parity;
  logic                  result_rdy;
  logic                  arg_parity_error;
  logic [1:0]            dbg_state;

  modport master (
    output req, arg_a, arg_a_parity, arg_b, arg_b_parity,
    input  ack, result, result_parity, result_rdy, arg_parity_error, dbg_state
  );

  modport slave (
    input  req, arg_a, arg_a_parity, arg_b, arg_b_parity,
    output ack, result, result_parity, result_rdy, arg_parity_error, dbg_state
  );
endinterface

// File: rtl/mult_seq_core.sv
// Sequential signed multiplier with parity-checked operands.
// The datapath is a radix-2 shift-add over operand magnitudes, with the sign applied at the end.
module mult_seq_core #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_seq_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ERR  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  state_t               state, state_next;
  logic                 capture_en, iter_en, done_en, err_en;
  logic                 par_ok;

  logic                 sign_q;
  logic [2*DATA_W-1:0]  mcand;
  logic [DATA_W:0]      mplier;
  logic [2*DATA_W-1:0]  acc;
  logic [CNT_W-1:0]     count;

  logic [DATA_W:0]      a_ext, b_ext, a_mag, b_mag;
  logic [2*DATA_W-1:0]  signed_prod;

  logic                 ack_q, result_rdy_q, result_parity_q, arg_parity_error_q;
  logic [2*DATA_W-1:0]  result_q;

  // One extra bit so that the magnitude of the most negative operand is representable.
  assign a_ext = {bus.arg_a[DATA_W-1], bus.arg_a};
  assign b_ext = {bus.arg_b[DATA_W-1], bus.arg_b};
  assign a_mag = a_ext[DATA_W] ? (~a_ext + (DATA_W+1)'(1)) : a_ext;
  assign b_mag = b_ext[DATA_W] ? (~b_ext + (DATA_W+1)'(1)) : b_ext;

  assign par_ok = (bus.arg_a_parity == ^bus.arg_a) && (bus.arg_b_parity == ^bus.arg_b);

  assign signed_prod = sign_q ? (~acc + (2*DATA_W)'(1)) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture_en = 1'b0;
    iter_en    = 1'b0;
    done_en    = 1'b0;
    err_en     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          capture_en = 1'b1;
          state_next = par_ok ? CALC : ERR;
        end
      end
      CALC: begin
        iter_en = 1'b1;
        if (count == LAST_ITER) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_en    = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        err_en     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q             <= 1'b0;
      mcand              <= '0;
      mplier             <= '0;
      acc                <= '0;
      count              <= '0;
      ack_q              <= 1'b0;
      result_rdy_q       <= 1'b0;
      result_q           <= '0;
      result_parity_q    <= 1'b0;
      arg_parity_error_q <= 1'b0;
    end else begin
      ack_q        <= capture_en;
      result_rdy_q <= done_en | err_en;

      if (capture_en) begin
        sign_q <= bus.arg_a[DATA_W-1] ^ bus.arg_b[DATA_W-1];
        mcand  <= {{(DATA_W-1){1'b0}}, a_mag};
        mplier <= b_mag;
        acc    <= '0;
        count  <= '0;
      end

      if (iter_en) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CNT_W'(1);
      end

      if (done_en) begin
        result_q           <= signed_prod;
        result_parity_q    <= ^signed_prod;
        arg_parity_error_q <= 1'b0;
      end

      if (err_en) begin
        result_q           <= '0;
        result_parity_q    <= 1'b0;
        arg_parity_error_q <= 1'b1;
      end
    end
  end

  assign bus.ack              = ack_q;
  assign bus.result_rdy       = result_rdy_q;
  assign bus.result           = result_q;
  assign bus.result_parity    = result_parity_q;
  assign bus.arg_parity_error = arg_parity_error_q;
  assign bus.dbg_state        = state;

endmodule

// File: tb/tb_mult_seq_core.sv
// Self-checking bench for mult_seq_core: directed corner cases, back-to-back requests,
// an abort by reset, and random operands compared against a plain-arithmetic reference.
module tb_mult_seq_core;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_seq_if #(.DATA_W(W)) bus ();

  mult_seq_core #(.DATA_W(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;
  logic [2*W+1:0] exp_q[$];

  always @(negedge clk) if (bus.ack === 1'b1) ack_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {arg_parity_error, result_parity, result}.
  function automatic logic [2*W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic pa, input logic pb);
    logic signed [W-1:0] sa, sb;
    logic [2*W-1:0]      p;
    if (pa != ^a || pb != ^b) return {1'b1, 1'b0, {(2*W){1'b0}}};
    sa = a;
    sb = b;
    p  = (2*W)'(longint'(sa) * longint'(sb));
    return {1'b0, ^p, p};
  endfunction

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic pa, input logic pb, input bit hold);
    logic [2*W+1:0] exp;
    int lat;
    int exp_lat;
    bit seen;
    bus.arg_a = a;  bus.arg_a_parity = pa;
    bus.arg_b = b;  bus.arg_b_parity = pb;
    bus.req   = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(a, b, pa, pb));
    @(negedge clk);
    check("ack", 64'(bus.ack), 64'(1));
    check("rdy_with_ack", 64'(bus.result_rdy), 64'(0));
    if (!hold) bus.req = 1'b0;
    bus.arg_a = W'($urandom);
    bus.arg_b = W'($urandom);
    bus.arg_a_parity = 1'($urandom);
    bus.arg_b_parity = 1'($urandom);
    exp     = exp_q.pop_front();
    exp_lat = exp[2*W+1] ? 1 : 17;
    seen    = 1'b0;
    lat     = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.result_rdy) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", 64'(bus.result), 64'(exp[2*W-1:0]));
    check("result_parity", 64'(bus.result_parity), 64'(exp[2*W]));
    check("arg_parity_error", 64'(bus.arg_parity_error), 64'(exp[2*W+1]));
    if (!hold) begin
      @(negedge clk);
      check("rdy_single_cycle", 64'(bus.result_rdy), 64'(0));
      check("result_hold", 64'(bus.result), 64'(exp[2*W-1:0]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acks0;
    int rdy_seen;
    logic [W-1:0] a, b;
    logic pa, pb;

    rst_n = 1'b0;
    bus.req = 1'b0;
    bus.arg_a = '0; bus.arg_b = '0;
    bus.arg_a_parity = 1'b0; bus.arg_b_parity = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(bus.ack), 64'(0));
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_parity", 64'(bus.result_parity), 64'(0));
    check("rst_rdy", 64'(bus.result_rdy), 64'(0));
    check("rst_err", 64'(bus.arg_parity_error), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corners, including a parity error followed by a clean transaction.
    run_txn(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    check("dir_7fff_sq", 64'(bus.result), 64'h3FFF0001);
    run_txn(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0);
    check("dir_8000_sq", 64'(bus.result), 64'h40000000);
    run_txn(16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0);
    check("dir_mixed", 64'(bus.result), 64'hC0008000);
    run_txn(16'h7FFF, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_txn(16'h0003, 16'hFFFB, 1'b0, ^16'hFFFB, 1'b0);
    check("err_cleared", 64'(bus.arg_parity_error), 64'(0));
    run_txn(16'h0000, 16'hFFF3, 1'b0, ^16'hFFF3, 1'b0);
    run_txn(16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_txn(16'h1234, 16'h5678, ~(^16'h1234), ~(^16'h5678), 1'b0);

    // req held high across three transactions; operands scrambled mid-calculation.
    acks0 = ack_cnt;
    run_txn(16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b1);
    run_txn(16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    run_txn(16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0);
    check("b2b_ack_count", 64'(ack_cnt - acks0), 64'(3));

    // Reset during CALC aborts without a result.
    bus.arg_a = 16'h1111; bus.arg_a_parity = ^16'h1111;
    bus.arg_b = 16'h2222; bus.arg_b_parity = ^16'h2222;
    bus.req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_ack", 64'(bus.ack), 64'(1));
    bus.req = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_result", 64'(bus.result), 64'(0));
    check("async_parity", 64'(bus.result_parity), 64'(0));
    check("async_err", 64'(bus.arg_parity_error), 64'(0));
    check("async_rdy", 64'(bus.result_rdy), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.result_rdy) rdy_seen++;
    end
    check("abort_no_rdy", 64'(rdy_seen), 64'(0));
    run_txn(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    // Random operands with occasional zeros and corrupted parity.
    repeat (24) begin
      a  = W'($urandom);
      b  = W'($urandom);
      if ($urandom_range(0, 7) == 0) a = '0;
      if ($urandom_range(0, 7) == 0) b = W'(16'h8000);
      pa = (^a) ^ ($urandom_range(0, 4) == 0);
      pb = (^b) ^ ($urandom_range(0, 4) == 0);
      run_txn(a, b, pa, pb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
